// File: rtl/uart_byte_rx_if.sv
`timescale 1ns/1ps
// Receiver-side bundle for uart_byte_rx: serial line in, byte/strobe/status out.
// valid and frame_err are single-cycle strobes with no ready; the consumer must take every one.
interface uart_byte_rx_if;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  modport slave (
    input  rxd,
    output data, valid, frame_err, busy, state_dbg
  );

  modport master (
    output rxd,
    input  data, valid, frame_err, busy, state_dbg
  );
endinterface

// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// Oversampling 8N1 UART receiver: 2-flop synchroniser, 3-sample majority per bit,
// one-cycle valid/frame_err strobes, single clock domain.
module uart_byte_rx #(
  parameter int OVERSAMPLE = 8
) (
  input logic           clk_uart,
  input logic           rst,
  uart_byte_rx_if.slave rx_if
);

  localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [PW-1:0] PH_PRE  = PW'(M - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(M);
  localparam logic [PW-1:0] PH_DEC  = PW'(M + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          sync1_q, sync2_q;
  logic          rxs;
  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, phase_inc;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          s_pre_q, s_pre_d;
  logic          s_mid_q, s_mid_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          maj;

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_if.rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // The third vote is the live sample taken in the decision cycle itself.
  assign maj = (s_pre_q & s_mid_q) | (s_pre_q & rxs) | (s_mid_q & rxs);

  assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      s_pre_q   <= 1'b1;
      s_mid_q   <= 1'b1;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      s_pre_q   <= s_pre_d;
      s_mid_q   <= s_mid_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    s_pre_d   = s_pre_q;
    s_mid_d   = s_mid_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (state_q != S_IDLE && phase_q == PH_PRE) s_pre_d = rxs;
    if (state_q != S_IDLE && phase_q == PH_MID) s_mid_d = rxs;

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        // The cycle that first sees the low line is phase 0 of the start cell.
        if (!rxs) begin
          state_d = S_START;
          phase_d = PW'(1);
        end
      end

      S_START: begin
        phase_d = phase_inc;
        if (phase_q == PH_DEC && maj) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else if (phase_q == PH_LAST) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end

      S_DATA: begin
        phase_d = phase_inc;
        if (phase_q == PH_DEC) shreg_d[bit_idx_q] = maj;
        if (phase_q == PH_LAST) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        phase_d = phase_inc;
        // Leaving mid-cell buys baud-mismatch margin and allows gapless frames.
        if (phase_q == PH_DEC) begin
          phase_d = '0;
          if (maj) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        phase_d = '0;
        if (rxs) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign rx_if.data      = data_q;
  assign rx_if.valid     = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.busy      = (state_q != S_IDLE);
  assign rx_if.state_dbg = state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
`timescale 1ns/1ps
// Bench for uart_byte_rx: one instance at 8x and one at 4x oversampling, driven
// with serial frames and checked against a frame-level model and a byte queue.
module tb_uart_byte_rx;

  logic clk_uart = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_uart = ~clk_uart;

  uart_byte_rx_if bus8 ();
  uart_byte_rx_if bus4 ();

  uart_byte_rx #(.OVERSAMPLE(8)) dut8 (.clk_uart(clk_uart), .rst(rst), .rx_if(bus8));
  uart_byte_rx #(.OVERSAMPLE(4)) dut4 (.clk_uart(clk_uart), .rst(rst), .rx_if(bus4));

  int cyc = 0;
  always @(posedge clk_uart) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed events
  logic [7:0] got8_q[$], got4_q[$];
  int         got8_t[$], got4_t[$];
  int         err8_n, err4_n, err8_t;
  int         busy8_rise, busy8_fall;
  bit         busy8_prev, pulse8_prev, pulse4_prev;
  int         viol8 = 0, viol4 = 0;

  // Reference model state
  logic [7:0] exp8_q[$], exp4_q[$];
  int         exp8_err, exp4_err;
  logic [7:0] model_data8, model_data4;

  initial begin
    bit p;
    busy8_prev  = 1'b0;
    pulse8_prev = 1'b0;
    pulse4_prev = 1'b0;
    forever begin
      @(negedge clk_uart);
      if (bus8.valid === 1'b1) begin got8_q.push_back(bus8.data); got8_t.push_back(cyc); end
      if (bus8.frame_err === 1'b1) begin err8_n++; err8_t = cyc; end
      if (bus8.busy === 1'b1 && !busy8_prev) busy8_rise = cyc;
      if (bus8.busy !== 1'b1 && busy8_prev) busy8_fall = cyc;
      busy8_prev = (bus8.busy === 1'b1);
      p = (bus8.valid === 1'b1) || (bus8.frame_err === 1'b1);
      if (((bus8.valid === 1'b1) && (bus8.frame_err === 1'b1)) || (p && pulse8_prev)) viol8++;
      pulse8_prev = p;

      if (bus4.valid === 1'b1) begin got4_q.push_back(bus4.data); got4_t.push_back(cyc); end
      if (bus4.frame_err === 1'b1) err4_n++;
      p = (bus4.valid === 1'b1) || (bus4.frame_err === 1'b1);
      if (((bus4.valid === 1'b1) && (bus4.frame_err === 1'b1)) || (p && pulse4_prev)) viol4++;
      pulse4_prev = p;
    end
  end

  task automatic clear_mon();
    got8_q.delete(); got8_t.delete(); got4_q.delete(); got4_t.delete();
    exp8_q.delete(); exp4_q.delete();
    err8_n = 0; err4_n = 0; err8_t = -1;
    exp8_err = 0; exp4_err = 0;
    busy8_rise = -1; busy8_fall = -1;
  endtask

  // Frame-level model: a frame with a high stop bit yields its byte, otherwise one error.
  task automatic model_frame(input bit sel4, input logic [7:0] b, input logic stop_v);
    if (stop_v) begin
      if (sel4) begin exp4_q.push_back(b); model_data4 = b; end
      else      begin exp8_q.push_back(b); model_data8 = b; end
    end else begin
      if (sel4) exp4_err++;
      else      exp8_err++;
    end
  endtask

  task automatic drive_line(input bit sel4, input logic v);
    if (sel4) bus4.rxd = v;
    else      bus8.rxd = v;
  endtask

  task automatic send_idle(input bit sel4, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_uart); #1;
      drive_line(sel4, 1'b1);
    end
  endtask

  // Bit period given in hundredths of a clock cycle; glitch_at forces one cycle high.
  task automatic send_frame(input bit sel4, input logic [7:0] b, input logic stop_v,
                            input int per_x100, input int glitch_at, output int fall_cyc);
    logic [9:0] bits;
    int total, bitpos;
    bits  = {stop_v, b, 1'b0};
    total = (10 * per_x100 + 99) / 100;
    fall_cyc = -1;
    for (int i = 0; i < total; i++) begin
      @(posedge clk_uart); #1;
      if (i == 0) fall_cyc = cyc;
      bitpos = (i * 100) / per_x100;
      if (bitpos > 9) bitpos = 9;
      drive_line(sel4, (i == glitch_at) ? 1'b1 : bits[bitpos]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.rxd = 1'b1;
    bus4.rxd = 1'b1;
    model_data8 = 8'h00;
    model_data4 = 8'h00;
    repeat (4) @(posedge clk_uart);
    @(negedge clk_uart);
    n_checks++; if (bus8.data !== 8'h00) begin n_fail++; $display("FAIL reset_data8: got %h want 00", bus8.data); end
    n_checks++; if (bus8.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid8: got %b want 0", bus8.valid); end
    n_checks++; if (bus8.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr8: got %b want 0", bus8.frame_err); end
    n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b want 0", bus8.busy); end
    n_checks++; if (bus4.data !== 8'h00) begin n_fail++; $display("FAIL reset_data4: got %h want 00", bus4.data); end
    n_checks++; if (bus4.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b want 0", bus4.valid); end
    n_checks++; if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b want 0", bus4.busy); end
    @(posedge clk_uart); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk_uart);
  endtask

  task automatic test_single_byte();
    int fall;
    clear_mon();
    model_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h55, 1'b1, 800, -1, fall);
    send_idle(1'b0, 40);
    n_checks++; if (got8_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got8_q.size()); end
    n_checks++; if (((got8_q.size() > 0) ? got8_q[0] : 8'hxx) !== exp8_q[0]) begin n_fail++; $display("FAIL single_data: got %h want %h", (got8_q.size() > 0) ? got8_q[0] : 8'hxx, exp8_q[0]); end
    n_checks++; if (((got8_t.size() > 0) ? got8_t[0] : -1) !== fall + 2 + 78) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", (got8_t.size() > 0) ? got8_t[0] : -1, fall + 80); end
    n_checks++; if (err8_n !== exp8_err) begin n_fail++; $display("FAIL single_ferr: got %0d want %0d", err8_n, exp8_err); end
    n_checks++; if (busy8_rise !== fall + 2 + 1) begin n_fail++; $display("FAIL single_busy_rise: got %0d want %0d", busy8_rise, fall + 3); end
    n_checks++; if (busy8_fall !== fall + 2 + 78) begin n_fail++; $display("FAIL single_busy_fall: got %0d want %0d", busy8_fall, fall + 80); end
  endtask

  task automatic test_sensor_frame(input int gap_bits);
    logic [7:0] fb[11];
    logic [7:0] sum;
    logic [7:0] obs;
    int fall;
    fb[0] = 8'h55; fb[1] = 8'h51; fb[2] = 8'h23; fb[3] = 8'h01; fb[4] = 8'h67;
    fb[5] = 8'h45; fb[6] = 8'hab; fb[7] = 8'h89; fb[8] = 8'hef; fb[9] = 8'hcd;
    sum = 8'h00;
    for (int i = 0; i < 10; i++) sum = sum + fb[i];
    fb[10] = sum;
    clear_mon();
    for (int i = 0; i < 11; i++) begin
      model_frame(1'b1, fb[i], 1'b1);
      send_frame(1'b1, fb[i], 1'b1, 400, -1, fall);
      if (gap_bits > 0) send_idle(1'b1, gap_bits * 4);
    end
    send_idle(1'b1, 20);
    n_checks++; if (got4_q.size() !== exp4_q.size()) begin n_fail++; $display("FAIL sensor_count gap=%0d: got %0d want %0d", gap_bits, got4_q.size(), exp4_q.size()); end
    for (int i = 0; i < exp4_q.size(); i++) begin
      obs = (i < got4_q.size()) ? got4_q[i] : 8'hxx;
      n_checks++; if (obs !== exp4_q[i]) begin n_fail++; $display("FAIL sensor_byte%0d gap=%0d: got %h want %h", i, gap_bits, obs, exp4_q[i]); end
    end
    n_checks++; if (err4_n !== 0) begin n_fail++; $display("FAIL sensor_ferr gap=%0d: got %0d want 0", gap_bits, err4_n); end
  endtask

  task automatic test_glitch();
    int fall;
    bit ok;
    clear_mon();
    @(posedge clk_uart); #1;
    bus8.rxd = 1'b0;
    fall = cyc;
    @(posedge clk_uart); #1;
    @(posedge clk_uart); #1;
    bus8.rxd = 1'b1;
    send_idle(1'b0, 100);
    n_checks++; if (got8_q.size() !== 0) begin n_fail++; $display("FAIL glitch_start_valid: got %0d want 0", got8_q.size()); end
    n_checks++; if (err8_n !== 0) begin n_fail++; $display("FAIL glitch_start_ferr: got %0d want 0", err8_n); end
    ok = (busy8_fall >= 0) && (busy8_fall <= fall + 2 + 6);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_fall: got %0d want <= %0d", busy8_fall, fall + 8); end

    clear_mon();
    model_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b0, 8'h00, 1'b1, 800, 4 * 8 + 4, fall);
    send_idle(1'b0, 40);
    n_checks++; if (got8_q.size() !== 1) begin n_fail++; $display("FAIL glitch_data_count: got %0d want 1", got8_q.size()); end
    n_checks++; if (((got8_q.size() > 0) ? got8_q[0] : 8'hxx) !== exp8_q[0]) begin n_fail++; $display("FAIL glitch_data: got %h want %h", (got8_q.size() > 0) ? got8_q[0] : 8'hxx, exp8_q[0]); end
  endtask

  task automatic test_framing_error();
    int fall, fall_bad;
    clear_mon();
    model_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h55, 1'b1, 800, -1, fall);
    send_idle(1'b0, 16);
    model_frame(1'b0, 8'h00, 1'b0);
    send_frame(1'b0, 8'h00, 1'b0, 800, -1, fall_bad);
    repeat (50 * 8) @(posedge clk_uart);
    @(negedge clk_uart);
    n_checks++; if (err8_n !== exp8_err) begin n_fail++; $display("FAIL ferr_count: got %0d want %0d", err8_n, exp8_err); end
    n_checks++; if (err8_t !== fall_bad + 2 + 78) begin n_fail++; $display("FAIL ferr_latency: got %0d want %0d", err8_t, fall_bad + 80); end
    n_checks++; if (bus8.data !== model_data8) begin n_fail++; $display("FAIL ferr_data_hold: got %h want %h", bus8.data, model_data8); end
    n_checks++; if (got8_q.size() !== exp8_q.size()) begin n_fail++; $display("FAIL ferr_valid_count: got %0d want %0d", got8_q.size(), exp8_q.size()); end
    n_checks++; if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b want 1", bus8.busy); end
    send_idle(1'b0, 16);
    @(negedge clk_uart);
    n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b want 0", bus8.busy); end
    model_frame(1'b0, 8'hA7, 1'b1);
    send_frame(1'b0, 8'hA7, 1'b1, 800, -1, fall);
    send_idle(1'b0, 40);
    n_checks++; if (((got8_q.size() > 1) ? got8_q[1] : 8'hxx) !== exp8_q[1]) begin n_fail++; $display("FAIL ferr_recover_data: got %h want %h", (got8_q.size() > 1) ? got8_q[1] : 8'hxx, exp8_q[1]); end
    n_checks++; if (err8_n !== exp8_err) begin n_fail++; $display("FAIL ferr_recover_count: got %0d want %0d", err8_n, exp8_err); end
  endtask

  task automatic test_reset_mid_byte();
    int fall;
    clear_mon();
    @(posedge clk_uart); #1;
    bus8.rxd = 1'b0;
    fall = cyc;
    for (int i = 1; i < 8 + 4 * 8 + 4; i++) begin
      @(posedge clk_uart); #1;
      bus8.rxd = (i < 8) ? 1'b0 : 1'b1;
    end
    rst = 1'b1;
    model_data8 = 8'h00;
    model_data4 = 8'h00;
    @(posedge clk_uart);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_uart);
      n_checks++; if (bus8.data !== model_data8) begin n_fail++; $display("FAIL rstmid_data%0d: got %h want %h", k, bus8.data, model_data8); end
      n_checks++; if (bus8.valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid%0d: got %b want 0", k, bus8.valid); end
      n_checks++; if (bus8.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr%0d: got %b want 0", k, bus8.frame_err); end
      n_checks++; if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy%0d: got %b want 0", k, bus8.busy); end
    end
    @(posedge clk_uart); #1;
    rst = 1'b0;
    send_idle(1'b0, 10 * 8);
    n_checks++; if ((got8_q.size() + err8_n) !== 0) begin n_fail++; $display("FAIL rstmid_aborted_pulse: got %0d want 0", got8_q.size() + err8_n); end
    model_frame(1'b0, 8'h3C, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b1, 800, -1, fall);
    send_idle(1'b0, 40);
    n_checks++; if (got8_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", got8_q.size()); end
    n_checks++; if (((got8_q.size() > 0) ? got8_q[0] : 8'hxx) !== exp8_q[0]) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", (got8_q.size() > 0) ? got8_q[0] : 8'hxx, exp8_q[0]); end
  endtask

  task automatic test_baud_tolerance();
    int pers[2];
    int fall;
    pers[0] = 816;
    pers[1] = 784;
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      model_frame(1'b0, 8'h96, 1'b1);
      send_frame(1'b0, 8'h96, 1'b1, pers[k], -1, fall);
      send_idle(1'b0, 40);
      n_checks++; if (((got8_q.size() > 0) ? got8_q[0] : 8'hxx) !== exp8_q[0]) begin n_fail++; $display("FAIL baud_%0d_data: got %h want %h", pers[k], (got8_q.size() > 0) ? got8_q[0] : 8'hxx, exp8_q[0]); end
      n_checks++; if (err8_n !== 0) begin n_fail++; $display("FAIL baud_%0d_ferr: got %0d want 0", pers[k], err8_n); end
    end
  endtask

  task automatic test_random_bytes();
    logic [7:0] b, obs;
    int fall, per, os;
    for (int s = 0; s < 2; s++) begin
      clear_mon();
      os = (s == 1) ? 4 : 8;
      for (int i = 0; i < 12; i++) begin
        b   = 8'($urandom_range(0, 255));
        per = (s == 1) ? $urandom_range(396, 404) : $urandom_range(784, 816);
        model_frame(s[0], b, 1'b1);
        send_frame(s[0], b, 1'b1, per, -1, fall);
        send_idle(s[0], $urandom_range(0, 3) * os);
      end
      send_idle(s[0], 5 * os);
      if (s == 1) begin
        n_checks++; if (got4_q.size() !== exp4_q.size()) begin n_fail++; $display("FAIL rand4_count: got %0d want %0d", got4_q.size(), exp4_q.size()); end
        for (int i = 0; i < exp4_q.size(); i++) begin
          obs = (i < got4_q.size()) ? got4_q[i] : 8'hxx;
          n_checks++; if (obs !== exp4_q[i]) begin n_fail++; $display("FAIL rand4_byte%0d: got %h want %h", i, obs, exp4_q[i]); end
        end
        n_checks++; if (err4_n !== exp4_err) begin n_fail++; $display("FAIL rand4_ferr: got %0d want %0d", err4_n, exp4_err); end
      end else begin
        n_checks++; if (got8_q.size() !== exp8_q.size()) begin n_fail++; $display("FAIL rand8_count: got %0d want %0d", got8_q.size(), exp8_q.size()); end
        for (int i = 0; i < exp8_q.size(); i++) begin
          obs = (i < got8_q.size()) ? got8_q[i] : 8'hxx;
          n_checks++; if (obs !== exp8_q[i]) begin n_fail++; $display("FAIL rand8_byte%0d: got %h want %h", i, obs, exp8_q[i]); end
        end
        n_checks++; if (err8_n !== exp8_err) begin n_fail++; $display("FAIL rand8_ferr: got %0d want %0d", err8_n, exp8_err); end
      end
    end
  endtask

  task automatic test_pulse_rules();
    n_checks++; if (viol8 !== 0) begin n_fail++; $display("FAIL pulse_rules8: got %0d violations want 0", viol8); end
    n_checks++; if (viol4 !== 0) begin n_fail++; $display("FAIL pulse_rules4: got %0d violations want 0", viol4); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_byte();
    test_sensor_frame(1);
    test_sensor_frame(0);
    test_glitch();
    test_framing_error();
    test_reset_mid_byte();
    test_baud_tolerance();
    test_random_bytes();
    test_pulse_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
